// File: rtl/sargantana_icache_victim_sel_if.sv
// Request/response and update bundle for the instruction-cache victim selector.
// Handshake: a request is accepted whenever req_valid_i is high (no ready, no backpressure);
// resp_valid_o pulses exactly one cycle later. touch/fill/flush are fire-and-forget strobes.
interface sargantana_icache_victim_sel_if #(
  parameter int unsigned N_WAY = 4,
  parameter int unsigned N_SET = 64
);
  localparam int unsigned WAY_W = $clog2(N_WAY);
  localparam int unsigned SET_W = $clog2(N_SET);

  logic             req_valid_i;
  logic [SET_W-1:0] req_set_i;
  logic [N_WAY-1:0] req_valid_ways_i;
  logic             resp_valid_o;
  logic [WAY_W-1:0] resp_way_o;
  logic [N_WAY-1:0] resp_way_oh_o;
  logic             resp_invalid_o;
  logic             touch_valid_i;
  logic [SET_W-1:0] touch_set_i;
  logic [WAY_W-1:0] touch_way_i;
  logic             fill_valid_i;
  logic [SET_W-1:0] fill_set_i;
  logic [WAY_W-1:0] fill_way_i;
  logic             flush_i;

  modport master (
    output req_valid_i, req_set_i, req_valid_ways_i,
    output touch_valid_i, touch_set_i, touch_way_i,
    output fill_valid_i, fill_set_i, fill_way_i, flush_i,
    input  resp_valid_o, resp_way_o, resp_way_oh_o, resp_invalid_o
  );

  modport slave (
    input  req_valid_i, req_set_i, req_valid_ways_i,
    input  touch_valid_i, touch_set_i, touch_way_i,
    input  fill_valid_i, fill_set_i, fill_way_i, flush_i,
    output resp_valid_o, resp_way_o, resp_way_oh_o, resp_invalid_o
  );
endinterface

// File: rtl/sargantana_icache_victim_sel.sv
// Victim-way selector: lowest invalid way first, else tree-PLRU or round-robin per set.
// One registered response per request, one cycle after the request.
module sargantana_icache_victim_sel #(
  parameter int unsigned N_WAY  = 4,
  parameter int unsigned N_SET  = 64,
  parameter int unsigned POLICY = 0
) (
  input logic                          clk_i,
  input logic                          rst_i,
  sargantana_icache_victim_sel_if.slave bus
);
  localparam int unsigned WAY_W = $clog2(N_WAY);

  typedef logic [WAY_W-1:0] way_t;

  logic             inv_any;
  way_t             inv_way;
  way_t             pol_way;
  way_t             sel_way;
  logic [N_WAY-1:0] sel_oh;

  logic             resp_valid_q;
  way_t             resp_way_q;
  logic [N_WAY-1:0] resp_oh_q;
  logic             resp_inv_q;

  // Scan from the top so the lowest-index invalid way wins.
  always_comb begin
    inv_any = ~&bus.req_valid_ways_i;
    inv_way = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!bus.req_valid_ways_i[i]) inv_way = way_t'(i);
    end
  end

  always_comb begin
    sel_way = inv_any ? inv_way : pol_way;
    sel_oh  = '0;
    for (int i = 0; i < N_WAY; i++) sel_oh[i] = (sel_way == way_t'(i));
  end

  generate
    if (POLICY == 0) begin : g_plru
      logic [N_SET-1:0][N_WAY-2:0] plru_q;

      // Follow node bits from the root; each level contributes the next way bit, MSB first.
      function automatic way_t plru_walk(input logic [N_WAY-2:0] t);
        way_t node;
        way_t way;
        logic b;
        node = '0;
        way  = '0;
        for (int k = 0; k < WAY_W; k++) begin
          b    = t[node];
          way  = way_t'({way, b});
          node = way_t'(2 * int'(node) + 1 + int'(b));
        end
        return way;
      endfunction

      // Point every node on w's path away from w.
      function automatic logic [N_WAY-2:0] plru_upd(input logic [N_WAY-2:0] t, input way_t w);
        logic [N_WAY-2:0] r;
        way_t             node;
        way_t             rest;
        logic             b;
        r    = t;
        node = '0;
        rest = w;
        for (int k = 0; k < WAY_W; k++) begin
          b       = rest[WAY_W-1];
          r[node] = ~b;
          rest    = rest << 1;
          node    = way_t'(2 * int'(node) + 1 + int'(b));
        end
        return r;
      endfunction

      // A fill to the same set as a touch overrides it; the later write below wins.
      always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
          plru_q <= '0;
        end else begin
          if (bus.touch_valid_i && !(bus.fill_valid_i && bus.fill_set_i == bus.touch_set_i))
            plru_q[bus.touch_set_i] <= plru_upd(plru_q[bus.touch_set_i], bus.touch_way_i);
          if (bus.fill_valid_i)
            plru_q[bus.fill_set_i] <= plru_upd(plru_q[bus.fill_set_i], bus.fill_way_i);
        end
      end

      assign pol_way = plru_walk(plru_q[bus.req_set_i]);
    end else begin : g_rr
      logic [N_SET-1:0][WAY_W-1:0] rr_q;
      logic                        unused_touch;

      // Hits carry no information for round-robin.
      assign unused_touch = ^{bus.touch_valid_i, bus.touch_set_i, bus.touch_way_i};

      always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
          rr_q <= '0;
        end else if (bus.fill_valid_i) begin
          rr_q[bus.fill_set_i] <= rr_q[bus.fill_set_i] + way_t'(1);
        end
      end

      assign pol_way = rr_q[bus.req_set_i];
    end
  endgenerate

  // Way/one-hot/invalid hold their value between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_oh_q    <= '0;
      resp_inv_q   <= 1'b0;
    end else begin
      resp_valid_q <= bus.req_valid_i;
      if (bus.req_valid_i) begin
        resp_way_q <= sel_way;
        resp_oh_q  <= sel_oh;
        resp_inv_q <= inv_any;
      end
    end
  end

  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.resp_way_o     = resp_way_q;
  assign bus.resp_way_oh_o  = resp_oh_q;
  assign bus.resp_invalid_o = resp_inv_q;
endmodule

// File: tb/tb_sargantana_icache_victim_sel.sv
// Bench for the victim selector: a 4-way PLRU instance and an 8-way round-robin instance
// run in lockstep against a behavioural model, with directed scenarios then random traffic.
module tb_sargantana_icache_victim_sel;
  localparam int PW = 4, PS = 64, PWW = 2;
  localparam int RW = 8, RS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sargantana_icache_victim_sel_if #(.N_WAY(PW), .N_SET(PS)) pif ();
  sargantana_icache_victim_sel_if #(.N_WAY(RW), .N_SET(RS)) rif ();

  sargantana_icache_victim_sel #(.N_WAY(PW), .N_SET(PS), .POLICY(0)) dut_plru (
    .clk_i(clk), .rst_i(rst), .bus(pif.slave)
  );
  sargantana_icache_victim_sel #(.N_WAY(RW), .N_SET(RS), .POLICY(1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .bus(rif.slave)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Behavioural model state.
  bit pm [PS][PW-1];
  int rm [RS];
  int pm_way, pm_oh, pm_inv;
  int rm_way, rm_oh, rm_inv;

  // Expected record: [31] p valid, [30] p invalid, [27:24] p way, [23:20] p one-hot,
  //                  [15] r valid, [14] r invalid, [10:8] r way, [7:0] r one-hot.
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int low_zero(input int v, input int n);
    for (int i = 0; i < n; i++) if (((v >> i) & 1) == 0) return i;
    return -1;
  endfunction

  // The PLRU victim is the way whose whole root-to-leaf path points toward it.
  function automatic int plru_victim(input int s);
    for (int w = 0; w < PW; w++) begin
      bit ok = 1'b1;
      for (int k = 0; k < PWW; k++) begin
        int node = (1 << k) - 1 + (w >> (PWW - k));
        int bk   = (w >> (PWW - 1 - k)) & 1;
        if (int'(pm[s][node]) != bk) ok = 1'b0;
      end
      if (ok) return w;
    end
    return -1;
  endfunction

  task automatic plru_mark(input int s, input int w);
    for (int k = 0; k < PWW; k++) begin
      int node = (1 << k) - 1 + (w >> (PWW - k));
      int bk   = (w >> (PWW - 1 - k)) & 1;
      pm[s][node] = (bk == 0);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < PS; s++) for (int n = 0; n < PW - 1; n++) pm[s][n] = 1'b0;
    for (int s = 0; s < RS; s++) rm[s] = 0;
  endtask

  task automatic idle();
    rst = 1'b0;
    pif.req_valid_i = 1'b0; pif.req_set_i = '0; pif.req_valid_ways_i = '1;
    pif.touch_valid_i = 1'b0; pif.touch_set_i = '0; pif.touch_way_i = '0;
    pif.fill_valid_i = 1'b0; pif.fill_set_i = '0; pif.fill_way_i = '0; pif.flush_i = 1'b0;
    rif.req_valid_i = 1'b0; rif.req_set_i = '0; rif.req_valid_ways_i = '1;
    rif.touch_valid_i = 1'b0; rif.touch_set_i = '0; rif.touch_way_i = '0;
    rif.fill_valid_i = 1'b0; rif.fill_set_i = '0; rif.fill_way_i = '0; rif.flush_i = 1'b0;
  endtask

  task automatic preq(input int s, input int ways);
    pif.req_valid_i = 1'b1; pif.req_set_i = 6'(s); pif.req_valid_ways_i = 4'(ways);
  endtask
  task automatic ptouch(input int s, input int w);
    pif.touch_valid_i = 1'b1; pif.touch_set_i = 6'(s); pif.touch_way_i = 2'(w);
  endtask
  task automatic pfill(input int s, input int w);
    pif.fill_valid_i = 1'b1; pif.fill_set_i = 6'(s); pif.fill_way_i = 2'(w);
  endtask

  // Predict from current inputs, advance one clock, compare, return inputs to idle.
  task automatic tick();
    logic [31:0] e;
    e = '0;
    if (rst) begin
      clear_model();
      pm_way = 0; pm_oh = 0; pm_inv = 0;
      rm_way = 0; rm_oh = 0; rm_inv = 0;
    end else begin
      if (pif.req_valid_i) begin
        int z = low_zero(int'(pif.req_valid_ways_i), PW);
        e[31]  = 1'b1;
        pm_inv = (z >= 0);
        pm_way = (z >= 0) ? z : plru_victim(int'(pif.req_set_i));
        pm_oh  = 1 << pm_way;
      end
      if (rif.req_valid_i) begin
        int z = low_zero(int'(rif.req_valid_ways_i), RW);
        e[15]  = 1'b1;
        rm_inv = (z >= 0);
        rm_way = (z >= 0) ? z : rm[int'(rif.req_set_i)];
        rm_oh  = 1 << rm_way;
      end
      if (pif.flush_i) begin
        for (int s = 0; s < PS; s++) for (int n = 0; n < PW - 1; n++) pm[s][n] = 1'b0;
      end else begin
        if (pif.touch_valid_i && !(pif.fill_valid_i && pif.fill_set_i == pif.touch_set_i))
          plru_mark(int'(pif.touch_set_i), int'(pif.touch_way_i));
        if (pif.fill_valid_i) plru_mark(int'(pif.fill_set_i), int'(pif.fill_way_i));
      end
      if (rif.flush_i) begin
        for (int s = 0; s < RS; s++) rm[s] = 0;
      end else if (rif.fill_valid_i) begin
        rm[int'(rif.fill_set_i)] = (rm[int'(rif.fill_set_i)] + 1) % RW;
      end
    end
    e[30] = pm_inv[0]; e[27:24] = 4'(pm_way); e[23:20] = 4'(pm_oh);
    e[14] = rm_inv[0]; e[10:8]  = 3'(rm_way); e[7:0]   = 8'(rm_oh);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("p_valid", 32'(pif.resp_valid_o), 32'(e[31]));
    check("p_way", 32'(pif.resp_way_o), 32'(e[27:24]));
    check("p_oh", 32'(pif.resp_way_oh_o), 32'(e[23:20]));
    if (e[31]) check("p_inv", 32'(pif.resp_invalid_o), 32'(e[30]));
    check("r_valid", 32'(rif.resp_valid_o), 32'(e[15]));
    check("r_way", 32'(rif.resp_way_o), 32'(e[10:8]));
    check("r_oh", 32'(rif.resp_way_oh_o), 32'(e[7:0]));
    if (e[15]) check("r_inv", 32'(rif.resp_invalid_o), 32'(e[14]));
    idle();
  endtask

  task automatic flush_both();
    pif.flush_i = 1'b1; rif.flush_i = 1'b1;
    tick();
  endtask

  initial begin
    clear_model();
    idle();
    pm_way = 0; pm_oh = 0; pm_inv = 0;
    rm_way = 0; rm_oh = 0; rm_inv = 0;

    // Reset values
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    check("rst_valid", 32'(pif.resp_valid_o), 0);
    check("rst_way", 32'(pif.resp_way_o), 0);
    check("rst_oh", 32'(pif.resp_way_oh_o), 0);
    check("rst_inv", 32'(pif.resp_invalid_o), 0);

    // First request after reset, then silence
    preq(5, 'hF); tick();
    check("first_valid", 32'(pif.resp_valid_o), 1);
    check("first_way", 32'(pif.resp_way_o), 0);
    check("first_oh", 32'(pif.resp_way_oh_o), 1);
    check("first_inv", 32'(pif.resp_invalid_o), 0);
    tick();
    check("idle_valid", 32'(pif.resp_valid_o), 0);

    // Invalid-way priority
    preq(5, 'hB); tick();
    check("inv_way", 32'(pif.resp_way_o), 2);
    check("inv_flag", 32'(pif.resp_invalid_o), 1);
    preq(5, 'h0); tick();
    check("inv0_way", 32'(pif.resp_way_o), 0);
    check("inv0_flag", 32'(pif.resp_invalid_o), 1);

    // PLRU sequence on set 5
    ptouch(5, 0); tick();
    preq(5, 'hF); tick();
    check("plru_touch0", 32'(pif.resp_way_o), 2);
    pfill(5, 2); tick();
    preq(5, 'hF); tick();
    check("plru_fill2", 32'(pif.resp_way_o), 1);
    preq(6, 'hF); tick();
    check("plru_set6", 32'(pif.resp_way_o), 0);

    // Touch and fill to the same set: fill only
    flush_both();
    ptouch(5, 0); pfill(5, 3); tick();
    preq(5, 'hF); tick();
    check("conflict_fill", 32'(pif.resp_way_o), 0);
    pfill(5, 1); pif.flush_i = 1'b1; tick();
    preq(5, 'hF); tick();
    check("flush_fill", 32'(pif.resp_way_o), 0);

    // Round-robin: eight fills on set 0, touches interleaved
    flush_both();
    for (int i = 0; i < RW; i++) begin
      rif.fill_valid_i = 1'b1; rif.fill_set_i = '0; rif.fill_way_i = 3'(i);
      rif.touch_valid_i = 1'b1; rif.touch_set_i = '0; rif.touch_way_i = 3'($urandom_range(0, RW - 1));
      tick();
      rif.req_valid_i = 1'b1; rif.req_set_i = '0; rif.req_valid_ways_i = '1;
      rif.touch_valid_i = 1'b1; rif.touch_set_i = '0; rif.touch_way_i = 3'($urandom_range(0, RW - 1));
      tick();
      check("rr_seq", 32'(rif.resp_way_o), 32'((i + 1) % RW));
    end

    // Back-to-back requests, no same-cycle bypass
    flush_both();
    preq(1, 'hF); pfill(1, 0); tick();
    check("b2b_first", 32'(pif.resp_way_o), 0);
    preq(2, 'hF); tick();
    check("b2b_mid_valid", 32'(pif.resp_valid_o), 1);
    preq(1, 'hF); tick();
    check("b2b_third", 32'(pif.resp_way_o), 2);
    check("b2b_third_valid", 32'(pif.resp_valid_o), 1);

    // Same pattern with reset on the third request
    flush_both();
    preq(1, 'hF); pfill(1, 0); tick();
    preq(2, 'hF); tick();
    preq(1, 'hF); rst = 1'b1; tick();
    check("b2b_rst_valid", 32'(pif.resp_valid_o), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      pif.req_valid_i      = 1'($urandom_range(0, 1));
      pif.req_set_i        = 6'($urandom_range(0, 3));
      pif.req_valid_ways_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      pif.touch_valid_i    = 1'($urandom_range(0, 1));
      pif.touch_set_i      = 6'($urandom_range(0, 3));
      pif.touch_way_i      = 2'($urandom_range(0, PW - 1));
      pif.fill_valid_i     = 1'($urandom_range(0, 1));
      pif.fill_set_i       = 6'($urandom_range(0, 3));
      pif.fill_way_i       = 2'($urandom_range(0, PW - 1));
      pif.flush_i          = ($urandom_range(0, 59) == 0);
      rif.req_valid_i      = 1'($urandom_range(0, 1));
      rif.req_set_i        = 3'($urandom_range(0, 3));
      rif.req_valid_ways_i = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      rif.touch_valid_i    = 1'($urandom_range(0, 1));
      rif.touch_set_i      = 3'($urandom_range(0, 3));
      rif.touch_way_i      = 3'($urandom_range(0, RW - 1));
      rif.fill_valid_i     = 1'($urandom_range(0, 1));
      rif.fill_set_i       = 3'($urandom_range(0, 3));
      rif.fill_way_i       = 3'($urandom_range(0, RW - 1));
      rif.flush_i          = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
